// File: rtl/dot_matrix_scroller.sv
// Column-scan LED matrix driver with a writable glyph buffer and a scrolling window.
// Outputs are registered (1-cycle latency); there is no backpressure and writes never stall.
module dot_matrix_scroller #(
    parameter int N_COLS        = 5,
    parameter int N_ROWS        = 7,
    parameter int BUF_DEPTH     = 16,
    parameter int SCAN_DIV      = 5400000,
    parameter int SCROLL_FRAMES = 4,
    localparam int AW           = $clog2(BUF_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [N_ROWS-1:0] i_wr_data,
    input  logic              i_scroll_en,
    input  logic              i_blank,
    output logic [1:0]        o_portA,
    output logic [1:0]        o_portB,
    output logic [N_ROWS-1:0] o_row,
    output logic [N_COLS-1:0] o_col,
    output logic              o_frame_tick
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [AW:0]   DEPTH     = (AW+1)'(BUF_DEPTH);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(N_COLS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_FRAMES - 1);

    logic [SW-1:0]     r_scan_cnt;
    logic [CW-1:0]     r_col_idx;
    logic [FW-1:0]     r_frame_cnt;
    logic [AW-1:0]     r_offset;
    logic [N_ROWS-1:0] r_buf [BUF_DEPTH];
    logic [1:0]        r_portA;
    logic [1:0]        r_portB;
    logic [N_ROWS-1:0] r_row;
    logic [N_COLS-1:0] r_col;
    logic              r_frame_tick;

    logic              w_tc;
    logic              w_frame_end;
    logic [AW:0]       w_sum;
    logic [AW:0]       w_rd_full;
    logic [AW-1:0]     w_rd_idx;
    logic [AW:0]       w_off_inc;
    logic [AW-1:0]     w_offset_nxt;
    logic [N_COLS-1:0] w_col_sel;
    logic              w_wr_ok;

    // Window arithmetic carries one extra bit so non-power-of-2 depths wrap correctly.
    always_comb begin
        w_tc         = (r_scan_cnt == SCAN_LAST);
        w_frame_end  = w_tc && (r_col_idx == COL_LAST);
        w_sum        = {1'b0, r_offset} + (AW+1)'(r_col_idx);
        w_rd_full    = (w_sum >= DEPTH) ? (w_sum - DEPTH) : w_sum;
        w_rd_idx     = w_rd_full[AW-1:0];
        w_off_inc    = {1'b0, r_offset} + 1'b1;
        w_offset_nxt = (w_off_inc >= DEPTH) ? '0 : w_off_inc[AW-1:0];
        w_col_sel    = N_COLS'(1) << r_col_idx;
        w_wr_ok      = i_wr_en && ({1'b0, i_wr_addr} < DEPTH);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan_cnt   <= '0;
            r_col_idx    <= '0;
            r_frame_cnt  <= '0;
            r_offset     <= '0;
            r_portA      <= '0;
            r_portB      <= '0;
            r_row        <= '0;
            r_col        <= '1;
            r_frame_tick <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_portA      <= 2'b01;
            r_portB      <= 2'b01;
            r_frame_tick <= w_frame_end;
            r_scan_cnt   <= w_tc ? '0 : r_scan_cnt + 1'b1;

            if (w_tc) begin
                r_col_idx <= (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;
            end

            if (!i_scroll_en) begin
                r_frame_cnt <= '0;
            end else if (w_frame_end) begin
                if (r_frame_cnt == FRM_LAST) begin
                    r_frame_cnt <= '0;
                    r_offset    <= w_offset_nxt;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end

            // Blanking only gates the pins; the scan keeps running underneath.
            if (i_blank) begin
                r_row <= '0;
                r_col <= '1;
            end else begin
                r_row <= r_buf[w_rd_idx];
                r_col <= ~w_col_sel;
            end

            if (w_wr_ok) begin
                r_buf[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_portA      = r_portA;
    assign o_portB      = r_portB;
    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_frame_tick = r_frame_tick;

endmodule
